reg_file_dump: RTL and testbench
================================

Name: reg_file_dump

Overview:
- Parametrised, single-bank general-purpose register file for the pipelined CPU.
- Replaces the fixed 8-entry slices with one block of 2**ADDR_W x DATA_W registers, with an optional hardwired zero register.
- Two combinational read ports with optional same-cycle write-to-read bypass.
- A handshaked dump engine streams every register, one per beat, to the on-board debug/display path without stalling the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wD_i; 0 = returns the stored value.
- TAP_IDX, 19, index of the register driven continuously on tap_o.

Ports:
- clk_i  in  1  clock, all state on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- rR1_i  in  ADDR_W  read port 1 address.
- rR2_i  in  ADDR_W  read port 2 address.
- rD1_o  out  DATA_W  read port 1 data, combinational.
- rD2_o  out  DATA_W  read port 2 data, combinational.
- wR_i  in  ADDR_W  write address.
- wD_i  in  DATA_W  write data.
- WE_i  in  1  write enable.
- tap_o  out  DATA_W  stored value of register TAP_IDX, no bypass.
- dump_start_i  in  1  request a full dump; honoured only in IDLE.
- dump_abort_i  in  1  abort a dump in progress.
- dump_valid_o  out  1  dump beat valid.
- dump_ready_i  in  1  consumer accepts the beat.
- dump_idx_o  out  ADDR_W  index of the current beat.
- dump_data_o  out  DATA_W  data of the current beat.
- dump_busy_o  out  1  high when the FSM is not IDLE.
- dump_done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - All registers are cleared to 0.
  - FSM goes to IDLE.
  - dump_valid_o, dump_busy_o, dump_done_o, dump_idx_o and dump_data_o are all 0.
  - Reset asserted mid-dump abandons the dump immediately, with no done pulse.
- Write:
  - At the rising edge, if WE_i=1, reg[wR_i] <= wD_i.
  - If ZERO_REG=1 and wR_i=0, the write is discarded.
- Read (combinational):
  - rDx_o = reg[rRx_i].
  - If ZERO_REG=1 and rRx_i=0, rDx_o = 0, including when bypass would otherwise apply.
  - If BYPASS=1, WE_i=1 and wR_i==rRx_i (and the address is not the discarded zero register), rDx_o = wD_i.
  - Both ports may read the same address.
- "Effective value" of address a = the value read port 1 would return for a in that cycle.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: if dump_start_i=1 and dump_abort_i=0 at an edge, then dump_idx_o <= 0, dump_data_o <= effective value of address 0, dump_valid_o <= 1, go to SEND. Valid rises one cycle after start is sampled.
  - SEND, dump_valid_o=1 and dump_ready_i=0: dump_idx_o and dump_data_o hold stable. Writes to the presented register do not change dump_data_o.
  - SEND, handshake (valid&ready) with dump_idx_o < DEPTH-1: idx <= idx+1, dump_data_o <= effective value of idx+1 (includes a same-cycle write when BYPASS=1), valid stays 1. Throughput is one beat per cycle.
  - SEND, handshake with dump_idx_o = DEPTH-1: valid <= 0, go to DONE.
  - DONE: dump_done_o=1 for exactly this cycle, then IDLE.
  - dump_abort_i=1 in SEND: IDLE at the next edge, valid <= 0, no done pulse. Abort has priority over a simultaneous handshake. Abort in IDLE or DONE has no effect.
  - dump_start_i outside IDLE is ignored; no queuing.
- Outputs:
  - dump_busy_o = (state != IDLE), including DONE.
  - Normal read and write ports are fully independent of the FSM, and writes continue during a dump.
  - Registers not yet presented are captured at presentation time.
- Widths:
  - The index counter is ADDR_W bits and never wraps past DEPTH-1.
  - No arithmetic is done on the data.

Test Plan:
- Reset then reads: hold reset_n_i=0 two cycles, release; read all 32 addresses -> every rD1_o/rD2_o = 0, tap_o = 0, dump_valid_o = 0.
- Zero register and bypass: WE_i=1, wR_i=0, wD_i=32'hDEAD_BEEF -> rD1_o(rR1_i=0) = 0 that cycle and after. WE_i=1, wR_i=5, wD_i=32'h1234_5678 with rR2_i=5 -> rD2_o = 32'h1234_5678 in the same cycle (BYPASS=1); with BYPASS=0, old value 0 until the next cycle.
- Full dump, ready held high: preload reg[i] = i*3, pulse dump_start_i -> 32 consecutive beats idx 0..31 with data 0,3,...,93, then dump_done_o high for one cycle, then dump_busy_o = 0.
- Backpressure and concurrent write: at beat idx=7, hold dump_ready_i=0 for 4 cycles while writing reg[7]=32'hAAAA and reg[8]=32'hBBBB -> beat 7 data stays 21; next beat idx=8 shows 32'hBBBB.
- Abort and restart: abort at idx=10 while dump_ready_i=1 -> next cycle dump_valid_o=0, dump_busy_o=0, no dump_done_o; a new dump_start_i then restarts at idx=0. dump_start_i pulsed mid-dump -> no effect.
- Async reset mid-dump: drop reset_n_i between edges at idx=12 -> dump_valid_o and dump_busy_o fall immediately; all registers read 0 after release.

Source files
------------

// File: rtl/reg_file_dump.sv
// rtl/reg_file_dump.sv - parametrised register file with two bypassed read ports and a handshaked dump engine
module reg_file_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int TAP_IDX  = 19
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] rR1_i,
  input  logic [ADDR_W-1:0] rR2_i,
  output logic [DATA_W-1:0] rD1_o,
  output logic [DATA_W-1:0] rD2_o,
  input  logic [ADDR_W-1:0] wR_i,
  input  logic [DATA_W-1:0] wD_i,
  input  logic              WE_i,
  output logic [DATA_W-1:0] tap_o,
  input  logic              dump_start_i,
  input  logic              dump_abort_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_busy_o,
  output logic              dump_done_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TAP_ADDR = ADDR_W'(TAP_IDX);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic [ADDR_W-1:0] nxt_idx;
  logic [DATA_W-1:0] eff_first;
  logic [DATA_W-1:0] eff_next;

  // Value a read port returns for address a this cycle: zero register wins over bypass.
  function automatic logic [DATA_W-1:0] eff_val(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] wr,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS != 0 && we && wr == a) v = wd;
    if (ZERO_REG != 0 && a == '0) v = '0;
    return v;
  endfunction

  assign wr_ok     = WE_i && !(ZERO_REG != 0 && wR_i == '0);
  assign nxt_idx   = dump_idx_o + 1'b1;
  assign rD1_o     = eff_val(rR1_i, regs[rR1_i], WE_i, wR_i, wD_i);
  assign rD2_o     = eff_val(rR2_i, regs[rR2_i], WE_i, wR_i, wD_i);
  assign eff_first = eff_val('0, regs[0], WE_i, wR_i, wD_i);
  assign eff_next  = eff_val(nxt_idx, regs[nxt_idx], WE_i, wR_i, wD_i);
  assign tap_o     = regs[TAP_ADDR];
  assign dump_busy_o = (state != IDLE);

  // Register array: cleared on reset, one write port, discarded writes to the zero register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wR_i] <= wD_i;
    end
  end

  // Dump engine: presents one register per beat, captured when it becomes the current beat.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      dump_valid_o <= 1'b0;
      dump_done_o  <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
    end else begin
      dump_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start_i && !dump_abort_i) begin
            state        <= SEND;
            dump_idx_o   <= '0;
            dump_data_o  <= eff_first;
            dump_valid_o <= 1'b1;
          end
        end
        SEND: begin
          if (dump_abort_i) begin
            state        <= IDLE;
            dump_valid_o <= 1'b0;
          end else if (dump_ready_i) begin
            if (dump_idx_o == LAST_IDX) begin
              state        <= DONE;
              dump_valid_o <= 1'b0;
              dump_done_o  <= 1'b1;
            end else begin
              dump_idx_o  <= nxt_idx;
              dump_data_o <= eff_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          dump_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump.sv
// tb/tb_reg_file_dump.sv - randomized self-checking bench for reg_file_dump against a behavioural model
module tb_reg_file_dump;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  r1, r2, wr;
  logic [31:0] rd1, rd2, wd, tap;
  logic        we;
  logic        start, abort, ready;
  logic        valid, busy, done;
  logic [4:0]  idx;
  logic [31:0] data;

  always #5 clk = ~clk;

  reg_file_dump dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .rR1_i(r1), .rR2_i(r2), .rD1_o(rd1), .rD2_o(rd2),
    .wR_i(wr), .wD_i(wd), .WE_i(we), .tap_o(tap),
    .dump_start_i(start), .dump_abort_i(abort),
    .dump_valid_o(valid), .dump_ready_i(ready),
    .dump_idx_o(idx), .dump_data_o(data),
    .dump_busy_o(busy), .dump_done_o(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: plain array of register contents plus dump progress.
  logic [31:0] m_mem [32];
  bit          m_busy, m_valid, m_done;
  int          m_idx;
  logic [31:0] m_data;
  logic [31:0] beats [$];
  int          done_cnt;

  function automatic logic [31:0] m_eff(input int a);
    if (a == 0) return 32'h0;
    if (we && int'(wr) == a) return wd;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_busy = 0; m_valid = 0; m_done = 0; m_idx = 0; m_data = 32'h0;
  endtask

  task automatic idle_in();
    we = 0; wr = 5'($urandom); wd = $urandom;
    r1 = 5'($urandom); r2 = 5'($urandom);
    start = 0; abort = 0; ready = 1;
  endtask

  // One clock: check everything against the model before the edge, then advance the model.
  task automatic tick();
    bit was_done;
    #1;
    check("rd1", rd1, m_eff(int'(r1)));
    check("rd2", rd2, m_eff(int'(r2)));
    check("tap", tap, m_mem[19]);
    check("valid", valid, m_valid);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (m_valid) begin
      check("idx", idx, m_idx);
      check("data", data, m_data);
    end
    if (valid && ready && !abort) beats.push_back(data);
    if (done) done_cnt++;
    @(posedge clk);
    was_done = m_done;
    m_done = 0;
    if (was_done) m_busy = 0;
    else if (m_valid) begin
      if (abort) begin
        m_valid = 0; m_busy = 0;
      end else if (ready) begin
        if (m_idx == 31) begin
          m_valid = 0; m_done = 1;
        end else begin
          m_idx++;
          m_data = m_eff(m_idx);
        end
      end
    end else if (!m_busy && start && !abort) begin
      m_busy = 1; m_valid = 1; m_idx = 0; m_data = m_eff(0);
    end
    if (we && wr != 0) m_mem[wr] = wd;
    @(negedge clk);
  endtask

  task automatic run_to_idx(input int target, input string tag);
    int n = 0;
    while (!(m_valid && m_idx == target) && n < 40) begin
      idle_in(); tick(); n++;
    end
    check(tag, idx, target);
  endtask

  initial begin
    reset_n = 0;
    idle_in();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", idx, 0);
    check("rst_data", data, 0);
    for (int a = 0; a < 32; a++) begin
      idle_in(); r1 = 5'(a); r2 = 5'(31 - a); tick();
    end

    // Zero register and same-cycle bypass
    idle_in(); we = 1; wr = 0; wd = 32'hDEAD_BEEF; r1 = 0;
    #1 check("zero_same", rd1, 0);
    tick();
    idle_in(); r1 = 0;
    #1 check("zero_after", rd1, 0);
    tick();
    idle_in(); we = 1; wr = 5; wd = 32'h1234_5678; r2 = 5;
    #1 check("bypass", rd2, 32'h1234_5678);
    tick();
    idle_in(); r2 = 5;
    #1 check("bypass_after", rd2, 32'h1234_5678);
    tick();

    // Preload reg[i] = i*3 and dump with ready held high
    for (int i = 1; i < 32; i++) begin
      idle_in(); we = 1; wr = 5'(i); wd = 32'(i * 3); tick();
    end
    beats.delete(); done_cnt = 0;
    idle_in(); start = 1; tick();
    for (int n = 0; n < 36; n++) begin
      idle_in(); tick();
    end
    check("beats", beats.size(), 32);
    for (int i = 0; i < beats.size() && i < 32; i++) check("beat_data", beats[i], 32'(i * 3));
    check("done_cnt", done_cnt, 1);
    check("idle_after", busy, 0);

    // Backpressure on beat 7 with writes to the presented and next register
    idle_in(); start = 1; tick();
    run_to_idx(7, "reach7");
    for (int k = 0; k < 4; k++) begin
      idle_in(); ready = 0;
      we = (k < 2); wr = (k == 0) ? 5'd7 : 5'd8; wd = (k == 0) ? 32'hAAAA : 32'hBBBB;
      tick();
      check("hold_idx", idx, 7);
      check("hold_data", data, 21);
    end
    idle_in(); tick();
    check("next_idx", idx, 8);
    check("next_data", data, 32'hBBBB);
    for (int n = 0; n < 30; n++) begin
      idle_in(); tick();
    end

    // Abort at beat 10, restart, and a start pulse mid-dump
    idle_in(); start = 1; tick();
    run_to_idx(10, "reach10");
    done_cnt = 0;
    idle_in(); abort = 1; tick();
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    idle_in(); tick();
    check("abort_nodone", done_cnt, 0);
    idle_in(); start = 1; tick();
    check("restart_idx", idx, 0);
    check("restart_valid", valid, 1);
    for (int n = 0; n < 4; n++) begin
      idle_in(); tick();
    end
    idle_in(); start = 1; tick();
    check("mid_start_idx", idx, 5);
    for (int n = 0; n < 32; n++) begin
      idle_in(); tick();
    end

    // Asynchronous reset in the middle of a dump
    idle_in(); start = 1; tick();
    run_to_idx(12, "reach12");
    idle_in();
    #2 reset_n = 0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    m_reset();
    @(negedge clk);
    reset_n = 1;
    for (int a = 0; a < 32; a++) begin
      idle_in(); r1 = 5'(a); r2 = 5'(a); tick();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      idle_in();
      we    = $urandom_range(1, 0) == 1;
      ready = $urandom_range(3, 0) != 0;
      start = $urandom_range(19, 0) == 0;
      abort = $urandom_range(49, 0) == 0;
      if ($urandom_range(3, 0) == 0) r1 = wr;
      if ($urandom_range(3, 0) == 0) r2 = wr;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
